// File: rtl/post_add_sub_acc.sv
// Post-adder/subtractor + accumulator stage of a DSP48A1-style slice: X/Z operand muxes, add/sub with carry, P feedback.
// Optional sticky overflow flag enabled by defining POST_ADD_SUB_OVF_EN.
module post_add_sub_acc #(
   parameter int    OPMODEREG  = 1,
   parameter int    CARRYINREG = 1,
   parameter int    CREG       = 1,
   parameter int    PREG       = 1,
   parameter string CARRYINSEL = "OPMODE5"
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CEOPMODE,
   input  logic        CECARRYIN,
   input  logic        CEC,
   input  logic        CEP,
   input  logic [7:0]  OPMODE,
   input  logic [35:0] M,
   input  logic [17:0] D,
   input  logic [17:0] A,
   input  logic [17:0] B,
   input  logic [47:0] C,
   input  logic [47:0] PCIN,
   input  logic        CARRYIN,
   output logic [47:0] P,
   output logic [47:0] PCOUT,
   output logic        CARRYOUT,
   output logic        CARRYOUTF,
   output logic        OVF
);

   localparam bit USE_CARRYIN_PORT = (CARRYINSEL == "CARRYIN");

   logic [7:0]  opm;
   logic [47:0] c_int;
   logic        cin_sel;
   logic        cin;
   logic [47:0] p_fb;
   logic [47:0] x_op;
   logic [47:0] z_op;
   logic [48:0] sum;

   // OPMODE[4] and [6] carry no function here; D[17:12] never reaches the concat.
   logic unused_bits;
   assign unused_bits = ^{opm[6], opm[4], D[17:12], CARRYIN, OPMODE[5]};

   generate
      if (OPMODEREG != 0) begin : g_opm_reg
         logic [7:0] opm_r;
         always_ff @(posedge CLK) begin
            if (RST)           opm_r <= '0;
            else if (CEOPMODE) opm_r <= OPMODE;
         end
         assign opm = opm_r;
      end else begin : g_opm_comb
         assign opm = OPMODE;
      end

      if (CREG != 0) begin : g_c_reg
         logic [47:0] c_r;
         always_ff @(posedge CLK) begin
            if (RST)      c_r <= '0;
            else if (CEC) c_r <= C;
         end
         assign c_int = c_r;
      end else begin : g_c_comb
         assign c_int = C;
      end
   endgenerate

   // Carry source is taken from the OPMODE port so carry and mode stay aligned when both stages are registered.
   assign cin_sel = USE_CARRYIN_PORT ? CARRYIN : OPMODE[5];

   generate
      if (CARRYINREG != 0) begin : g_cin_reg
         logic cin_r;
         always_ff @(posedge CLK) begin
            if (RST)            cin_r <= 1'b0;
            else if (CECARRYIN) cin_r <= cin_sel;
         end
         assign cin = cin_r;
      end else begin : g_cin_comb
         assign cin = cin_sel;
      end
   endgenerate

   always_comb begin
      x_op = '0;
      case (opm[1:0])
         2'b00: x_op = '0;
         2'b01: x_op = {12'b0, M};
         2'b10: x_op = p_fb;
         2'b11: x_op = {D[11:0], A, B};
         default: x_op = '0;
      endcase
      z_op = '0;
      case (opm[3:2])
         2'b00: z_op = '0;
         2'b01: z_op = PCIN;
         2'b10: z_op = p_fb;
         2'b11: z_op = c_int;
         default: z_op = '0;
      endcase
   end

   // Subtract: bit 48 of the 49-bit difference is the borrow.
   always_comb begin
      sum = '0;
      if (opm[7]) sum = {1'b0, z_op} - ({1'b0, x_op} + 49'(cin));
      else        sum = {1'b0, z_op} + {1'b0, x_op} + 49'(cin);
   end

   generate
      if (PREG != 0) begin : g_p_reg
         logic [47:0] p_r;
         logic        co_r;
         always_ff @(posedge CLK) begin
            if (RST) begin
               p_r  <= '0;
               co_r <= 1'b0;
            end else if (CEP) begin
               p_r  <= sum[47:0];
               co_r <= sum[48];
            end
         end
         assign P        = p_r;
         assign CARRYOUT = co_r;
         assign p_fb     = p_r;
      end else begin : g_p_comb
         // No P register means no feedback path; feedback selections read as 0.
         assign P        = sum[47:0];
         assign CARRYOUT = sum[48];
         assign p_fb     = '0;
      end
   endgenerate

   assign PCOUT     = P;
   assign CARRYOUTF = CARRYOUT;

`ifdef POST_ADD_SUB_OVF_EN
   logic ovf_r;
   always_ff @(posedge CLK) begin
      if (RST)                  ovf_r <= 1'b0;
      else if (CEP && sum[48])  ovf_r <= 1'b1;
   end
   assign OVF = ovf_r;
`else
   assign OVF = 1'b0;
`endif

endmodule
